// File: rtl/ann_layer_sequencer_pkg.sv
// Shared types and helpers for the ANN layer sequencer and the compute
// layers it drives.
package ann_pkg;

  localparam int DW_DEF = 32;

  typedef logic [DW_DEF-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_LATCH,
    ST_DONE
  } state_t;

  // Low bit of slice `idx` in a flattened bus of `width`-bit slices.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/ann_layer_sequencer_if.sv
// Input-vector and prediction handshakes between the data source/consumer
// (master) and the sequencer (slave).
interface ann_layer_sequencer_if #(
  parameter int NUM_IN = 4,
  parameter int DW     = 32
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_IN*DW-1:0] in_data;
  logic [DW-1:0]        pred;
  logic                 pred_valid;
  logic                 pred_ready;

  modport master (
    output in_valid, in_data, pred_ready,
    input  in_ready, pred, pred_valid
  );

  modport slave (
    input  in_valid, in_data, pred_ready,
    output in_ready, pred, pred_valid
  );
endinterface

// File: rtl/ann_layer_sequencer_timer.sv
// Compute-window timer: start loads 0 and counts up; done pulses on the
// cycle the count reaches LAYER_LATENCY-1, after which the count holds.
module layer_timer #(
  parameter  int LAYER_LATENCY = 65,
  localparam int CW            = $clog2(LAYER_LATENCY + 1)
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic clear,
  output logic done
);

  logic [CW-1:0] cnt;
  logic          running;

  assign done = running && (cnt == CW'(LAYER_LATENCY - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (done) running <= 1'b0;
      else      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ann_layer_sequencer.sv
// Runs an N-layer feed-forward datapath one layer at a time: enables each
// layer for its compute window, latches its outputs as the next operands.
module ann_layer_sequencer
  import ann_pkg::*;
#(
  parameter  int NUM_IN        = 4,
  parameter  int NUM_LAYERS    = 2,
  parameter  int LAYER_LATENCY = 65,
  parameter  int DW            = DW_DEF,
  localparam int IW            = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  ann_layer_sequencer_if.slave            bus,
  input  logic                            clear,
  output logic [NUM_LAYERS-1:0]           layer_rstn,
  output logic [NUM_IN*DW-1:0]            layer_in,
  input  logic [NUM_LAYERS*NUM_IN*DW-1:0] layer_out,
  output logic                            busy,
  output logic [IW-1:0]                   layer_idx
);

  localparam int VW = NUM_IN * DW;

  state_t state;
  logic   last;
  logic   t_start;
  logic   t_done;

  assign last    = (int'(layer_idx) == NUM_LAYERS - 1);
  assign t_start = !clear && (((state == ST_IDLE) && bus.in_valid) ||
                              ((state == ST_LATCH) && !last));

  assign bus.in_ready = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);

  layer_timer #(
    .LAYER_LATENCY(LAYER_LATENCY)
  ) u_timer (
    .clk  (clk),
    .rstn (rstn),
    .start(t_start),
    .clear(clear),
    .done (t_done)
  );

  // layer_rstn is one-hot while a layer runs; shifting it hands the enable
  // to the next layer on the same edge the previous one is released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      layer_rstn     <= '0;
      layer_in       <= '0;
      layer_idx      <= '0;
      bus.pred       <= '0;
      bus.pred_valid <= 1'b0;
    end else if (clear) begin
      state          <= ST_IDLE;
      layer_rstn     <= '0;
      bus.pred_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            layer_in   <= bus.in_data;
            layer_idx  <= '0;
            layer_rstn <= NUM_LAYERS'(1);
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (t_done) state <= ST_LATCH;
        end
        ST_LATCH: begin
          layer_in <= layer_out[slice_lo(int'(layer_idx), VW) +: VW];
          if (!last) begin
            layer_idx  <= layer_idx + 1'b1;
            layer_rstn <= layer_rstn << 1;
            state      <= ST_RUN;
          end else begin
            bus.pred       <= layer_out[slice_lo(NUM_LAYERS - 1, VW) +: DW];
            bus.pred_valid <= 1'b1;
            layer_rstn     <= '0;
            state          <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.pred_ready) begin
            bus.pred_valid <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Randomized bench for ann_layer_sequencer: three configurations share the
// stimulus, stub layers add 0x10*(k+1) per word, a timing/arithmetic model checks.
module tb_ann_layer_sequencer;
  import ann_pkg::*;

  localparam int W   = 32;
  localparam int LA  = 4,  NA = 2, NIA = 4;
  localparam int LB  = 65, NB = 2, NIB = 4;
  localparam int LC  = 1,  NC = 3, NIC = 2;

  logic         clk = 1'b0;
  logic         rstn, clear, in_valid, pred_ready;
  logic [127:0] in_data;
  int           sel;

  int checks   = 0;
  int failures = 0;
  int Lp [3]   = '{LA, LB, LC};
  int Np [3]   = '{NA, NB, NC};
  int NIp[3]   = '{NIA, NIB, NIC};
  logic [31:0] prev_pred [3];

  always #5 clk = ~clk;

  ann_layer_sequencer_if #(.NUM_IN(NIA), .DW(W)) if_a ();
  ann_layer_sequencer_if #(.NUM_IN(NIB), .DW(W)) if_b ();
  ann_layer_sequencer_if #(.NUM_IN(NIC), .DW(W)) if_c ();

  logic [NA-1:0]       lr_a;  logic [NIA*W-1:0] li_a;  logic [NA*NIA*W-1:0] lo_a;
  logic [NB-1:0]       lr_b;  logic [NIB*W-1:0] li_b;  logic [NB*NIB*W-1:0] lo_b;
  logic [NC-1:0]       lr_c;  logic [NIC*W-1:0] li_c;  logic [NC*NIC*W-1:0] lo_c;
  logic                busy_a, busy_b, busy_c;
  logic [0:0]          idx_a, idx_b;
  logic [1:0]          idx_c;

  assign if_a.in_valid   = in_valid && (sel == 0);
  assign if_b.in_valid   = in_valid && (sel == 1);
  assign if_c.in_valid   = in_valid && (sel == 2);
  assign if_a.in_data    = in_data;
  assign if_b.in_data    = in_data;
  assign if_c.in_data    = in_data[NIC*W-1:0];
  assign if_a.pred_ready = pred_ready;
  assign if_b.pred_ready = pred_ready;
  assign if_c.pred_ready = pred_ready;

  ann_layer_sequencer #(.NUM_IN(NIA), .NUM_LAYERS(NA), .LAYER_LATENCY(LA), .DW(W)) dut_a (
    .clk(clk), .rstn(rstn), .bus(if_a), .clear(clear), .layer_rstn(lr_a),
    .layer_in(li_a), .layer_out(lo_a), .busy(busy_a), .layer_idx(idx_a));

  ann_layer_sequencer #(.NUM_IN(NIB), .NUM_LAYERS(NB), .LAYER_LATENCY(LB), .DW(W)) dut_b (
    .clk(clk), .rstn(rstn), .bus(if_b), .clear(clear), .layer_rstn(lr_b),
    .layer_in(li_b), .layer_out(lo_b), .busy(busy_b), .layer_idx(idx_b));

  ann_layer_sequencer #(.NUM_IN(NIC), .NUM_LAYERS(NC), .LAYER_LATENCY(LC), .DW(W)) dut_c (
    .clk(clk), .rstn(rstn), .bus(if_c), .clear(clear), .layer_rstn(lr_c),
    .layer_in(li_c), .layer_out(lo_c), .busy(busy_c), .layer_idx(idx_c));

  // Stub layers: outputs valid a fixed number of cycles after enable rises.
  int age_a[NA], age_b[NB], age_c[NC];

  always @(posedge clk) begin
    for (int k = 0; k < NA; k++) age_a[k] <= lr_a[k] ? age_a[k] + 1 : 0;
    for (int k = 0; k < NB; k++) age_b[k] <= lr_b[k] ? age_b[k] + 1 : 0;
    for (int k = 0; k < NC; k++) age_c[k] <= lr_c[k] ? age_c[k] + 1 : 0;
  end

  always_comb begin
    lo_a = '0;
    lo_b = '0;
    lo_c = '0;
    for (int k = 0; k < NA; k++)
      for (int j = 0; j < NIA; j++)
        if (lr_a[k] && age_a[k] >= 3)
          lo_a[(k*NIA+j)*W +: W] = li_a[j*W +: W] + 32'h10 * (k + 1);
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < NIB; j++)
        if (lr_b[k] && age_b[k] >= 3)
          lo_b[(k*NIB+j)*W +: W] = li_b[j*W +: W] + 32'h10 * (k + 1);
    for (int k = 0; k < NC; k++)
      for (int j = 0; j < NIC; j++)
        if (lr_c[k] && age_c[k] >= 1)
          lo_c[(k*NIC+j)*W +: W] = li_c[j*W +: W] + 32'h10 * (k + 1);
  end

  logic [2:0]   o_lr;
  logic [127:0] o_li;
  logic [31:0]  o_pred;
  logic         o_pv, o_ir, o_busy;
  logic [1:0]   o_idx;

  always_comb begin
    o_lr = '0; o_li = '0; o_pred = '0; o_pv = 1'b0; o_ir = 1'b0; o_busy = 1'b0; o_idx = '0;
    case (sel)
      0: begin
        o_lr = {1'b0, lr_a}; o_li = li_a; o_pred = if_a.pred; o_pv = if_a.pred_valid;
        o_ir = if_a.in_ready; o_busy = busy_a; o_idx = {1'b0, idx_a};
      end
      1: begin
        o_lr = {1'b0, lr_b}; o_li = li_b; o_pred = if_b.pred; o_pv = if_b.pred_valid;
        o_ir = if_b.in_ready; o_busy = busy_b; o_idx = {1'b0, idx_b};
      end
      default: begin
        o_lr = lr_c; o_li = {64'h0, li_c}; o_pred = if_c.pred; o_pv = if_c.pred_valid;
        o_ir = if_c.in_ready; o_busy = busy_c; o_idx = idx_c;
      end
    endcase
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s (cfg %0d): got %0h expected %0h", tag, sel, got, exp);
    end
  endtask

  // Operand vector seen by layer k: each input word plus the stub offsets of layers 0..k-1.
  function automatic logic [127:0] operand(input logic [127:0] d, input int ni, input int k);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < ni; j++) r[j*32 +: 32] = d[j*32 +: 32] + 32'(16 * k * (k + 1) / 2);
    return r;
  endfunction

  function automatic logic [31:0] model_pred(input logic [127:0] d, input int n);
    return d[31:0] + 32'(16 * n * (n + 1) / 2);
  endfunction

  function automatic logic [127:0] rand_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ab_kind: 0 none, 1 clear pulse, 2 async reset; applied in cycle T+ab_m.
  task automatic run_txn(input logic [127:0] d, input int bp, input int ab_kind, input int ab_m);
    int L, N, NI, total, k, ph, b, to;
    logic [31:0] ep, kept;
    L = Lp[sel]; N = Np[sel]; NI = NIp[sel];
    total = N * (L + 1);
    ep = model_pred(d, N);
    to = 0;
    while (!o_ir && to < 300) begin
      @(negedge clk);
      to++;
    end
    if (!o_ir) begin
      check_eq("accept_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1; in_data = d; pred_ready = (bp == 0);
    for (int m = 1; m <= total + 1 + bp; m++) begin
      @(negedge clk);
      if (m <= total) begin
        k = (m - 1) / (L + 1); ph = (m - 1) % (L + 1);
        check_eq("layer_rstn", o_lr, 1 << k);
        check_eq("layer_idx", o_idx, k);
        check_eq("run_status", {o_busy, o_ir, o_pv}, 3'b100);
        check_eq("pred_hold_run", o_pred, prev_pred[sel]);
        if (ph == 0) check_eq("operand", o_li, operand(d, NI, k));
      end else begin
        b = m - total - 1;
        check_eq("done_status", {o_busy, o_ir, o_pv, o_lr}, 6'b101000);
        check_eq("pred", o_pred, ep);
        if (b == bp) pred_ready = 1'b1;
      end
      if (m == ab_m && ab_kind == 1) begin
        kept = (m > total) ? ep : prev_pred[sel];
        clear = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        check_eq("clear_idle", {o_busy, o_ir, o_pv, o_lr}, 6'b010000);
        check_eq("clear_pred_kept", o_pred, kept);
        @(negedge clk);
        check_eq("clear_stays_idle", {o_busy, o_ir, o_pv}, 3'b010);
        prev_pred[sel] = kept;
        return;
      end
      if (m == ab_m && ab_kind == 2) begin
        rstn = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("rst_ctrl", {o_busy, o_ir, o_pv, o_lr, o_idx}, 8'b01000000);
        check_eq("rst_layer_in", o_li, 0);
        check_eq("rst_pred", o_pred, 0);
        for (int s = 0; s < 3; s++) prev_pred[s] = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        return;
      end
      if (m == total + 1 + bp) in_valid = 1'b0;
      else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = rand_vec();
      end
    end
    @(negedge clk);
    check_eq("idle_after", {o_busy, o_ir, o_pv, o_lr}, 6'b010000);
    check_eq("pred_kept", o_pred, ep);
    prev_pred[sel] = ep;
  endtask

  initial begin
    int s, kind, am;
    rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; pred_ready = 1'b0; in_data = '0; sel = 0;
    for (int i = 0; i < 3; i++) prev_pred[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check_eq("reset_ctrl", {o_busy, o_ir, o_pv, o_lr, o_idx}, 8'b01000000);
      check_eq("reset_data", {o_li, o_pred}, 0);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    sel = 1; #1;
    run_txn({32'h41866666, 32'h400147AE, 32'h3FAE147B, 32'h414A3D71}, 0, 0, 0);

    sel = 0; #1;
    run_txn({32'd4, 32'd3, 32'd2, 32'd1}, 0, 0, 0);
    run_txn(rand_vec(), 7, 0, 0);
    run_txn(rand_vec(), 0, 1, 3);
    run_txn(rand_vec(), 0, 0, 0);

    clear = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    check_eq("clear_beats_accept", {o_busy, o_ir, o_lr}, 5'b01000);
    @(negedge clk);
    check_eq("clear_beats_accept2", {o_busy, o_ir, o_pv}, 3'b010);

    run_txn(rand_vec(), 3, 1, NA * (LA + 1) + 2);
    run_txn(rand_vec(), 0, 2, 6);
    run_txn(rand_vec(), 1, 0, 0);

    sel = 2; #1;
    run_txn({32'h0, 32'h0, 32'h200, 32'h100}, 0, 0, 0);
    run_txn(rand_vec(), 2, 0, 0);

    for (int it = 0; it < 14; it++) begin
      s = ($urandom_range(0, 4) == 0) ? 1 : (($urandom_range(0, 1) == 0) ? 0 : 2);
      sel = s; #1;
      kind = $urandom_range(0, 4);
      if (kind > 2) kind = 0;
      am = $urandom_range(1, Np[s] * (Lp[s] + 1) + 1);
      run_txn(rand_vec(), $urandom_range(0, 3), kind, am);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
